// File: rtl/fp_link_pkg.sv
// Shared definitions for the byte-serial floating-point multiplier link:
// host FSM state encoding and the link framing constants.
package fp_link_pkg;

    localparam int BYTE_W    = 8;
    localparam int OP_BYTES  = 16;
    localparam int RES_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_HOLD = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

endpackage

// File: rtl/fp_mult_host.sv
// Host adapter: serialises an operand pair to the byte-wide multiplier and
// reassembles its 8-byte product. Define FP_HOST_TIMEOUT_EN for the WAIT watchdog.
module fp_mult_host
    import fp_link_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [63:0]       op_a,
    input  logic [63:0]       op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_data,
    output logic              mul_enable,
    output logic [BYTE_W-1:0] mul_din,
    input  logic              mul_rdy,
    input  logic [BYTE_W-1:0] mul_dout,
    output logic              err,
    output state_t            dbg_state
);

    // Handshakes: a transfer happens on a rising CLK edge where valid and
    // ready are both 1; valid, once raised, holds its payload until that edge.

    localparam logic [3:0] SEND_LAST = 4'(OP_BYTES - 1);
    localparam logic [3:0] RECV_LAST = 4'(RES_BYTES - 1);
    localparam logic [7:0] GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t                     state_q;
    logic [OP_BYTES*BYTE_W-1:0] sh_q;
    logic [63:0]                res_q;
    logic [3:0]                 cnt_q;
    logic [7:0]                 gap_q;
    logic                       mul_en_q;
    logic [BYTE_W-1:0]          mul_din_q;
    logic                       res_valid_q;
    logic                       err_q;

`ifdef FP_HOST_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_q;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            mul_en_q    <= 1'b0;
            mul_din_q   <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef FP_HOST_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        // Byte 0 goes straight to mul_din; the rest wait in the shifter.
                        mul_din_q <= op_a[BYTE_W-1:0];
                        sh_q      <= {BYTE_W'(0), op_b, op_a[63:BYTE_W]};
                        mul_en_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cnt_q == SEND_LAST) begin
                        mul_en_q  <= 1'b0;
                        mul_din_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT;
`ifdef FP_HOST_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                    end else begin
                        mul_din_q <= sh_q[BYTE_W-1:0];
                        sh_q      <= sh_q >> BYTE_W;
                        cnt_q     <= cnt_q + 4'd1;
                    end
                end
                ST_WAIT, ST_RECV: begin
                    if (mul_rdy) begin
                        res_q <= {mul_dout, res_q[63:BYTE_W]};
                        if (cnt_q == RECV_LAST) begin
                            cnt_q       <= '0;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            cnt_q   <= cnt_q + 4'd1;
                            state_q <= ST_RECV;
                        end
                    end
`ifdef FP_HOST_TIMEOUT_EN
                    else if (state_q == ST_WAIT) begin
                        if (wd_q == WD_LAST) begin
                            err_q   <= 1'b1;
                            gap_q   <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            wd_q <= wd_q + 8'd1;
                        end
                    end
`endif
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        gap_q       <= '0;
                        state_q     <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_ready   = (state_q == ST_IDLE);
    assign res_valid  = res_valid_q;
    assign res_data   = res_q;
    assign mul_enable = mul_en_q;
    assign mul_din    = mul_din_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_mult_host.sv
// Directed and randomized checks of fp_mult_host against a behavioural
// multiplier model that returns real IEEE-754 products byte by byte.
`timescale 1ns/1ps
module tb_fp_mult_host;
    import fp_link_pkg::*;

    localparam int GAP = 2;
    localparam int TMO = 255;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        mul_enable;
    logic [7:0]  mul_din;
    logic        mul_rdy;
    logic [7:0]  mul_dout;
    logic        err;
    state_t      dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    int en_total = 0;
    int err_total = 0;

    // Multiplier model controls: 0 = real product, 1 = fixed bytes 11..88, 2 = silent
    int           model_mode = 0;
    int           model_delay = 0;
    bit           hole4 = 1'b0;
    bit           rand_holes = 1'b0;
    bit           spurious = 1'b0;
    logic [127:0] sent_vec = '0;

    fp_mult_host #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .mul_enable(mul_enable), .mul_din(mul_din), .mul_rdy(mul_rdy), .mul_dout(mul_dout),
        .err(err), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mul_enable) en_total++;
        if (err) err_total++;
    end

    // Behavioural multiplier: collects 16 bytes, waits, then returns 8 product bytes LSB first.
    initial begin : mul_model
        logic [127:0] acc;
        logic [63:0]  prod;
        int           rx_n, tx_i, wait_n;
        bit           busy, holed;
        acc = '0; prod = '0; rx_n = 0; tx_i = 0; wait_n = 0; busy = 1'b0; holed = 1'b0;
        mul_rdy = 1'b0;
        mul_dout = '0;
        forever begin
            @(posedge CLK); #2;
            mul_rdy = 1'b0;
            if (RESET) begin
                rx_n = 0;
                busy = 1'b0;
                continue;
            end
            if (busy) begin
                if (model_mode == 2) begin
                    mul_dout = 8'($urandom);
                end else if (wait_n > 0) begin
                    wait_n--;
                end else if ((hole4 && tx_i == 4 && !holed) || (rand_holes && $urandom_range(0, 3) == 0)) begin
                    holed = 1'b1;
                    mul_dout = 8'($urandom);
                end else begin
                    mul_rdy = 1'b1;
                    mul_dout = prod[tx_i*8 +: 8];
                    tx_i++;
                    if (tx_i == 8) busy = 1'b0;
                end
            end else if (mul_enable) begin
                acc = {mul_din, acc[127:8]};
                rx_n++;
                if (rx_n == 16) begin
                    sent_vec = acc;
                    rx_n = 0;
                    busy = 1'b1;
                    tx_i = 0;
                    holed = 1'b0;
                    wait_n = model_delay;
                    if (model_mode == 1) prod = 64'h8877665544332211;
                    else prod = $realtobits($bitstoreal(acc[63:0]) * $bitstoreal(acc[127:64]));
                end
            end else if (spurious) begin
                mul_rdy = 1'b1;
                mul_dout = 8'($urandom);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!op_ready && k < 200) begin
            tick();
            k++;
        end
        check({tag, " op_ready"}, op_ready, 1'b1);
    endtask

    task automatic wait_res(input string tag);
        int k;
        k = 0;
        while (!res_valid && k < 2000) begin
            tick();
            k++;
        end
        check({tag, " res_valid"}, res_valid, 1'b1);
    endtask

    function automatic logic [63:0] rand_dbl();
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[62:52] = 11'($urandom_range(900, 1150));
        return v;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, " res_valid drop"}, res_valid, 1'b0);
        check({tag, " op_ready in gap"}, op_ready, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int hold);
        int en0;
        wait_ready(tag);
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        en0 = en_total;
        tick();
        op_valid = 1'b0;
        check({tag, " first enable"}, mul_enable, 1'b1);
        check({tag, " first byte"}, mul_din, a[7:0]);
        wait_res(tag);
        check({tag, " enable count"}, en_total - en0, 16);
        check({tag, " byte stream"}, sent_vec, {b, a});
        check({tag, " res_data"}, res_data, exp);
        spurious = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, res_valid, 1'b1);
            check({tag, " hold data"}, res_data, exp);
            check({tag, " hold op_ready"}, op_ready, 1'b0);
        end
        handshake(tag);
        spurious = 1'b0;
    endtask

    initial begin : main
        logic [63:0] a, b, a2, b2;
        int k;
        bit saw_valid;

        // Reset state
        tick();
        tick();
        check("reset op_ready", op_ready, 1'b1);
        check("reset res_valid", res_valid, 1'b0);
        check("reset mul_enable", mul_enable, 1'b0);
        check("reset mul_din", mul_din, 8'h00);
        check("reset err", err, 1'b0);
        check("reset res_data", res_data, 64'h0);
        check("reset state", dbg_state, ST_IDLE);
        RESET = 1'b0;
        tick();

        // 1.0 * 2.0 through the real-product model
        model_mode = 0;
        model_delay = 2;
        run_op("one_x_two", 64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 0);
        check("one_x_two stream", sent_vec, 128'h4000000000000000_3FF0000000000000);

        // Fixed byte pattern with a one-cycle hole after byte 4, then a long HOLD
        model_mode = 1;
        model_delay = 3;
        hole4 = 1'b1;
        run_op("fixed_hole", rand_dbl(), rand_dbl(), 64'h8877665544332211, 10);
        hole4 = 1'b0;
        model_mode = 0;

        // Reset while the ninth operand byte is on the wire
        a = rand_dbl();
        b = rand_dbl();
        wait_ready("rst_send");
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rst_send byte9", mul_din, b[7:0]);
        check("rst_send enable", mul_enable, 1'b1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_send enable off", mul_enable, 1'b0);
        check("rst_send op_ready", op_ready, 1'b1);
        check("rst_send res_valid", res_valid, 1'b0);
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid) saw_valid = 1'b1;
        end
        check("rst_send no result", saw_valid, 1'b0);
        a = rand_dbl();
        b = rand_dbl();
        run_op("after_rst", a, b, ref_mul(a, b), 1);

        // Back-to-back with op_valid held high
        a = rand_dbl();  b = rand_dbl();
        a2 = rand_dbl(); b2 = rand_dbl();
        model_delay = 1;
        wait_ready("b2b");
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        tick();
        op_a = a2;
        op_b = b2;
        wait_res("b2b first");
        check("b2b first data", res_data, ref_mul(a, b));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        k = 0;
        while (!mul_enable && k < 20) begin
            tick();
            k++;
        end
        op_valid = 1'b0;
        check("b2b restart gap", k, GAP + 1);
        check("b2b second first byte", mul_din, a2[7:0]);
        wait_res("b2b second");
        check("b2b second stream", sent_vec, {b2, a2});
        check("b2b second data", res_data, ref_mul(a2, b2));
        handshake("b2b second");

        // Randomized operands, compute delays, rdy holes and HOLD lengths
        rand_holes = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = rand_dbl();
            b = rand_dbl();
            model_delay = $urandom_range(0, 6);
            run_op($sformatf("rand%0d", i), a, b, ref_mul(a, b), $urandom_range(0, 3));
        end
        rand_holes = 1'b0;

`ifdef FP_HOST_TIMEOUT_EN
        // Silent multiplier: watchdog must fire exactly TMO cycles after WAIT entry
        model_mode = 2;
        wait_ready("tmo");
        op_valid = 1'b1;
        op_a = rand_dbl();
        op_b = rand_dbl();
        tick();
        op_valid = 1'b0;
        k = 0;
        while (mul_enable && k < 40) begin
            tick();
            k++;
        end
        check("tmo send done", mul_enable, 1'b0);
        k = 0;
        saw_valid = 1'b0;
        while (!err && k < 400) begin
            tick();
            k++;
            if (res_valid) saw_valid = 1'b1;
        end
        check("tmo err delay", k, TMO);
        tick();
        check("tmo err one cycle", err, 1'b0);
        check("tmo no result", saw_valid, 1'b0);
        wait_ready("tmo recover");
        check("tmo err pulses", err_total, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        model_mode = 0;
        a = rand_dbl();
        b = rand_dbl();
        run_op("after_tmo", a, b, ref_mul(a, b), 0);
`else
        check("err never pulsed", err_total, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
